// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared MIPS decode constants used by the ID/EX stage:
//   - opcode / funct encodings of the supported instruction subset
//   - 4-bit ALU control codes (alu_op_e)
//   - dec_ctrl_t: control bundle produced by alu_ctrl_dec
// Optional feature macro of the stage using this package: ID_EX_FWD_EN.
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_op_e;

    // uses_rt: rt is a real source (drives the load-use compare on rt).
    // dst_is_rt: I-type style destination (rt) instead of rd.
    typedef struct packed {
        alu_op_e alu_op;
        logic    b_is_imm;
        logic    reg_wr;
        logic    dst_is_rt;
        logic    uses_rt;
        logic    mem_rd;
        logic    mem_wr;
        logic    illegal;
    } dec_ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
// Bundles every non-clock/reset signal of the ID/EX stage.
//   decode side : in_valid/in_ready, flush, opcode, funct, rs/rt/rd_idx,
//                 rs_data, rt_data, imm16
//   forwarding  : exm_wr_en, exm_rd, exm_result, exm_is_load,
//                 mwb_wr_en, mwb_rd, mwb_result
//   ALU side    : out_valid/out_ready, alu_a, alu_b, alucontrol, store_data,
//                 dst_idx, reg_wr_en, mem_rd, mem_wr, illegal, load_use
// Modports: slave = the stage itself, master = its environment.
// The forwarding group is only consumed when ID_EX_FWD_EN is defined.
// -----------------------------------------------------------------------------
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [RW-1:0] rs_idx;
    logic [RW-1:0] rt_idx;
    logic [RW-1:0] rd_idx;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [15:0]   imm16;
    logic          exm_wr_en;
    logic [RW-1:0] exm_rd;
    logic [DW-1:0] exm_result;
    logic          exm_is_load;
    logic          mwb_wr_en;
    logic [RW-1:0] mwb_rd;
    logic [DW-1:0] mwb_result;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alucontrol;
    logic [DW-1:0] store_data;
    logic [RW-1:0] dst_idx;
    logic          reg_wr_en;
    logic          mem_rd;
    logic          mem_wr;
    logic          illegal;
    logic          load_use;

    modport slave (
        input  in_valid, flush, opcode, funct, rs_idx, rt_idx, rd_idx,
               rs_data, rt_data, imm16, exm_wr_en, exm_rd, exm_result,
               exm_is_load, mwb_wr_en, mwb_rd, mwb_result, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alucontrol, store_data,
               dst_idx, reg_wr_en, mem_rd, mem_wr, illegal, load_use
    );

    modport master (
        output in_valid, flush, opcode, funct, rs_idx, rt_idx, rd_idx,
               rs_data, rt_data, imm16, exm_wr_en, exm_rd, exm_result,
               exm_is_load, mwb_wr_en, mwb_rd, mwb_result, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alucontrol, store_data,
               dst_idx, reg_wr_en, mem_rd, mem_wr, illegal, load_use
    );
endinterface

// File: rtl/alu_ctrl_dec.sv
// -----------------------------------------------------------------------------
// alu_ctrl_dec
// Purely combinational opcode/funct decoder.
//   opcode [5:0] in  : MIPS opcode
//   funct  [5:0] in  : MIPS funct (R-type only)
//   ctrl         out : ALU code, B-source, register/memory flags, illegal
// Anything outside the supported subset decodes to ALU_ADD with illegal=1
// and no register write.
// -----------------------------------------------------------------------------
module alu_ctrl_dec
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_ctrl_t  ctrl
);

    // Decode table; defaults describe the illegal-instruction response.
    always_comb begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.b_is_imm  = 1'b0;
        ctrl.reg_wr    = 1'b0;
        ctrl.dst_is_rt = 1'b1;
        ctrl.uses_rt   = 1'b0;
        ctrl.mem_rd    = 1'b0;
        ctrl.mem_wr    = 1'b0;
        ctrl.illegal   = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                ctrl.dst_is_rt = 1'b0;
                ctrl.uses_rt   = 1'b1;
                ctrl.reg_wr    = 1'b1;
                ctrl.illegal   = 1'b0;
                case (funct)
                    FN_ADD:  ctrl.alu_op = ALU_ADD;
                    FN_SUB:  ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    default: begin
                        ctrl.alu_op  = ALU_ADD;
                        ctrl.reg_wr  = 1'b0;
                        ctrl.illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                ctrl.b_is_imm = 1'b1;
                ctrl.reg_wr   = 1'b1;
                ctrl.mem_rd   = 1'b1;
                ctrl.illegal  = 1'b0;
            end
            OP_SW: begin
                // rt is the store data, so it is a real source
                ctrl.b_is_imm = 1'b1;
                ctrl.uses_rt  = 1'b1;
                ctrl.mem_wr   = 1'b1;
                ctrl.illegal  = 1'b0;
            end
            OP_ADDI: begin
                ctrl.b_is_imm = 1'b1;
                ctrl.reg_wr   = 1'b1;
                ctrl.illegal  = 1'b0;
            end
            OP_BEQ: begin
                ctrl.alu_op  = ALU_SUB;
                ctrl.uses_rt = 1'b1;
                ctrl.illegal = 1'b0;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register feeding the ALU through a registered valid/ready
// stage (1-cycle latency).
//   clk    in : system clock, rising edge
//   rst_n  in : asynchronous active-low reset
//   bus       : id_ex_stage_if.slave (decode inputs, forwarding inputs,
//               ALU-side outputs, in_ready and load_use)
// Optional feature: define ID_EX_FWD_EN to build the EX/MEM and MEM/WB
// forwarding muxes and the load-use hazard detector. Without it operands
// come straight from the register file and load_use is tied 0.
// -----------------------------------------------------------------------------
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input logic           clk,
    input logic           rst_n,
    id_ex_stage_if.slave  bus
);

    typedef struct packed {
        logic [DW-1:0] alu_a;
        logic [DW-1:0] alu_b;
        logic [3:0]    alucontrol;
        logic [DW-1:0] store_data;
        logic [RW-1:0] dst_idx;
        logic          reg_wr_en;
        logic          mem_rd;
        logic          mem_wr;
        logic          illegal;
    } payload_t;

    dec_ctrl_t     dec_s;
    logic [DW-1:0] rs_val_s;
    logic [DW-1:0] rt_val_s;
    logic [DW-1:0] imm_ext_s;
    logic [RW-1:0] dst_s;
    logic          load_use_s;
    logic          in_ready_s;
    logic          fire_s;
    payload_t      pay_d, pay_q;
    logic          valid_d, valid_q;

    alu_ctrl_dec u_dec (
        .opcode (bus.opcode),
        .funct  (bus.funct),
        .ctrl   (dec_s)
    );

`ifdef ID_EX_FWD_EN
    // EX/MEM wins over MEM/WB; a load in EX/MEM has no usable result yet,
    // and register 0 is never forwarded.
    function automatic logic [DW-1:0] fwd_sel(
        input logic [RW-1:0] idx,
        input logic [DW-1:0] rf_val,
        input logic          exm_ok,
        input logic [RW-1:0] exm_rd,
        input logic [DW-1:0] exm_val,
        input logic          mwb_ok,
        input logic [RW-1:0] mwb_rd,
        input logic [DW-1:0] mwb_val
    );
        logic [DW-1:0] sel;
        if (idx == '0) begin
            sel = rf_val;
        end else if (exm_ok && (exm_rd == idx)) begin
            sel = exm_val;
        end else if (mwb_ok && (mwb_rd == idx)) begin
            sel = mwb_val;
        end else begin
            sel = rf_val;
        end
        return sel;
    endfunction

    // Operand resolution through the forwarding muxes plus load-use compare.
    always_comb begin
        rs_val_s = fwd_sel(bus.rs_idx, bus.rs_data,
                           bus.exm_wr_en && !bus.exm_is_load, bus.exm_rd, bus.exm_result,
                           bus.mwb_wr_en, bus.mwb_rd, bus.mwb_result);
        rt_val_s = fwd_sel(bus.rt_idx, bus.rt_data,
                           bus.exm_wr_en && !bus.exm_is_load, bus.exm_rd, bus.exm_result,
                           bus.mwb_wr_en, bus.mwb_rd, bus.mwb_result);
        load_use_s = bus.in_valid && bus.exm_is_load && (bus.exm_rd != '0) &&
                     ((bus.exm_rd == bus.rs_idx) ||
                      (dec_s.uses_rt && (bus.exm_rd == bus.rt_idx)));
    end
`else
    logic unused_fwd_s;

    // Raw register-file operands; hazards are left to the instruction schedule.
    always_comb begin
        rs_val_s     = bus.rs_data;
        rt_val_s     = bus.rt_data;
        load_use_s   = 1'b0;
        unused_fwd_s = ^{bus.exm_wr_en, bus.exm_rd, bus.exm_result, bus.exm_is_load,
                         bus.mwb_wr_en, bus.mwb_rd, bus.mwb_result};
    end
`endif

    assign imm_ext_s  = {{(DW-16){bus.imm16[15]}}, bus.imm16};
    assign dst_s      = dec_s.dst_is_rt ? bus.rt_idx : bus.rd_idx;
    assign in_ready_s = !load_use_s && (!valid_q || bus.out_ready);
    assign fire_s     = bus.in_valid && in_ready_s;

    // Next-state: flush kills everything, otherwise capture or drain.
    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (fire_s) begin
            valid_d          = 1'b1;
            pay_d.alu_a      = rs_val_s;
            pay_d.alu_b      = dec_s.b_is_imm ? imm_ext_s : rt_val_s;
            pay_d.alucontrol = dec_s.alu_op;
            pay_d.store_data = rt_val_s;
            pay_d.dst_idx    = dst_s;
            pay_d.reg_wr_en  = dec_s.reg_wr && (dst_s != '0);
            pay_d.mem_rd     = dec_s.mem_rd;
            pay_d.mem_wr     = dec_s.mem_wr;
            pay_d.illegal    = dec_s.illegal;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Pipeline register; reset clears valid and every held field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.load_use   = load_use_s;
    assign bus.out_valid  = valid_q;
    assign bus.alu_a      = pay_q.alu_a;
    assign bus.alu_b      = pay_q.alu_b;
    assign bus.alucontrol = pay_q.alucontrol;
    assign bus.store_data = pay_q.store_data;
    assign bus.dst_idx    = pay_q.dst_idx;
    assign bus.reg_wr_en  = pay_q.reg_wr_en;
    assign bus.mem_rd     = pay_q.mem_rd;
    assign bus.mem_wr     = pay_q.mem_wr;
    assign bus.illegal    = pay_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage. Inputs change on the falling edge, the
// stage captures on the rising edge, results are sampled on the next falling
// edge. Expectations that depend on ID_EX_FWD_EN follow the same macro.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    id_ex_stage_if #(.DW(32), .RW(5)) bus ();

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.funct    = fn;
        bus.rs_idx   = rs;
        bus.rt_idx   = rt;
        bus.rd_idx   = rd;
        bus.rs_data  = rsd;
        bus.rt_data  = rtd;
        bus.imm16    = imm;
    endtask

    task automatic clear_fwd();
        bus.exm_wr_en   = 1'b0;
        bus.exm_rd      = 5'd0;
        bus.exm_result  = 32'h0;
        bus.exm_is_load = 1'b0;
        bus.mwb_wr_en   = 1'b0;
        bus.mwb_rd      = 5'd0;
        bus.mwb_result  = 32'h0;
    endtask

    // Drop in_valid and let any held instruction drain.
    task automatic go_idle();
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b0;
        drive(6'h00, 6'h20, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0);
        bus.in_valid = 1'b0;
        clear_fwd();
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        tests_run++;
        if ({bus.alu_a, bus.alu_b, bus.store_data} !== 96'h0) begin tests_failed++; $display("FAIL reset_operands: got %h %h %h want 0", bus.alu_a, bus.alu_b, bus.store_data); end
        tests_run++;
        if ({bus.alucontrol, bus.dst_idx, bus.reg_wr_en, bus.mem_rd, bus.mem_wr, bus.illegal} !== 13'h0) begin
            tests_failed++; $display("FAIL reset_ctrl: got ctl=%h dst=%0d wr=%b mrd=%b mwr=%b ill=%b want all 0",
                bus.alucontrol, bus.dst_idx, bus.reg_wr_en, bus.mem_rd, bus.mem_wr, bus.illegal);
        end
        tests_run++;
        if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0);
        @(negedge clk);
        tests_run++;
        if ({bus.out_valid, bus.alu_a, bus.alu_b} !== {1'b1, 32'd5, 32'd7}) begin
            tests_failed++; $display("FAIL rtype_operands: got v=%b a=%h b=%h want v=1 a=5 b=7", bus.out_valid, bus.alu_a, bus.alu_b);
        end
        tests_run++;
        if ({bus.alucontrol, bus.dst_idx, bus.reg_wr_en, bus.illegal} !== {4'b0010, 5'd3, 1'b1, 1'b0}) begin
            tests_failed++; $display("FAIL rtype_ctrl: got ctl=%b dst=%0d wr=%b ill=%b want 0010 3 1 0",
                bus.alucontrol, bus.dst_idx, bus.reg_wr_en, bus.illegal);
        end
    endtask

    typedef struct { logic [5:0] fn; logic [3:0] ctl; logic ill; } fvec_t;

    task automatic test_alu_funct();
        fvec_t v [5];
        v[0] = '{6'h22, 4'b0110, 1'b0};
        v[1] = '{6'h24, 4'b0000, 1'b0};
        v[2] = '{6'h25, 4'b0001, 1'b0};
        v[3] = '{6'h2A, 4'b0111, 1'b0};
        v[4] = '{6'h03, 4'b0010, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(6'h00, v[i].fn, 5'd1, 5'd2, 5'd5, 32'h100 + 32'(i), 32'h7, 16'h0);
            @(negedge clk);
            tests_run++;
            if ({bus.alucontrol, bus.illegal, bus.reg_wr_en, bus.dst_idx, bus.alu_a} !==
                {v[i].ctl, v[i].ill, ~v[i].ill, 5'd5, 32'h100 + 32'(i)}) begin
                tests_failed++; $display("FAIL funct_%h: got ctl=%b ill=%b wr=%b dst=%0d a=%h want ctl=%b ill=%b wr=%b dst=5 a=%h",
                    v[i].fn, bus.alucontrol, bus.illegal, bus.reg_wr_en, bus.dst_idx, bus.alu_a,
                    v[i].ctl, v[i].ill, ~v[i].ill, 32'h100 + 32'(i));
            end
        end
    endtask

    typedef struct {
        logic [5:0] op; logic [4:0] rt; logic [31:0] rtd; logic [15:0] imm;
        logic [31:0] b; logic [3:0] ctl; logic mrd; logic mwr; logic wr; logic ill;
    } ivec_t;

    task automatic test_immediate();
        ivec_t v [5];
        v[0] = '{6'h23, 5'd9,  32'h777,  16'hFFFC, 32'hFFFFFFFC, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0};
        v[1] = '{6'h2B, 5'd10, 32'h1234, 16'h0010, 32'h00000010, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0};
        v[2] = '{6'h08, 5'd0,  32'h0,    16'h7FFF, 32'h00007FFF, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0};
        v[3] = '{6'h04, 5'd11, 32'h55,   16'h8000, 32'h00000055, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0};
        v[4] = '{6'h3F, 5'd12, 32'h66,   16'h0001, 32'h00000066, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(v[i].op, 6'h20, 5'd1, v[i].rt, 5'd31, 32'h200 + 32'(i), v[i].rtd, v[i].imm);
            @(negedge clk);
            tests_run++;
            if ({bus.alu_a, bus.alu_b, bus.store_data} !== {32'h200 + 32'(i), v[i].b, v[i].rtd}) begin
                tests_failed++; $display("FAIL imm_op%h_data: got a=%h b=%h sd=%h want a=%h b=%h sd=%h", v[i].op,
                    bus.alu_a, bus.alu_b, bus.store_data, 32'h200 + 32'(i), v[i].b, v[i].rtd);
            end
            tests_run++;
            if ({bus.alucontrol, bus.mem_rd, bus.mem_wr, bus.reg_wr_en, bus.illegal, bus.dst_idx} !==
                {v[i].ctl, v[i].mrd, v[i].mwr, v[i].wr, v[i].ill, v[i].rt}) begin
                tests_failed++; $display("FAIL imm_op%h_ctrl: got ctl=%b mrd=%b mwr=%b wr=%b ill=%b dst=%0d want %b %b %b %b %b %0d", v[i].op,
                    bus.alucontrol, bus.mem_rd, bus.mem_wr, bus.reg_wr_en, bus.illegal, bus.dst_idx,
                    v[i].ctl, v[i].mrd, v[i].mwr, v[i].wr, v[i].ill, v[i].rt);
            end
        end
    endtask

    task automatic test_backpressure();
        go_idle();
        bus.out_ready = 1'b0;
        drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h11, 32'h1, 16'h0);
        @(negedge clk);
        tests_run++;
        if ({bus.out_valid, bus.alu_a} !== {1'b1, 32'h11}) begin tests_failed++; $display("FAIL bp_first: got v=%b a=%h want 1 11", bus.out_valid, bus.alu_a); end
        drive(6'h00, 6'h22, 5'd4, 5'd5, 5'd6, 32'h22, 32'h2, 16'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready_%0d: got %b want 0", i, bus.in_ready); end
            @(negedge clk);
            tests_run++;
            if ({bus.out_valid, bus.alu_a, bus.alucontrol, bus.dst_idx} !== {1'b1, 32'h11, 4'b0010, 5'd3}) begin
                tests_failed++; $display("FAIL bp_hold_%0d: got v=%b a=%h ctl=%b dst=%0d want 1 11 0010 3",
                    i, bus.out_valid, bus.alu_a, bus.alucontrol, bus.dst_idx);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        tests_run++;
        if ({bus.out_valid, bus.alu_a, bus.alucontrol, bus.dst_idx} !== {1'b1, 32'h22, 4'b0110, 5'd6}) begin
            tests_failed++; $display("FAIL bp_next: got v=%b a=%h ctl=%b dst=%0d want 1 22 0110 6",
                bus.out_valid, bus.alu_a, bus.alucontrol, bus.dst_idx);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
    endtask

    typedef struct { logic [4:0] rs; logic [4:0] exm_rd; logic mwb_en; logic [31:0] a; } fwvec_t;

    task automatic test_forward();
        fwvec_t v [4];
`ifdef ID_EX_FWD_EN
        v[0] = '{5'd4, 5'd4, 1'b1, 32'hAA};
        v[1] = '{5'd4, 5'd0, 1'b1, 32'hBB};
        v[2] = '{5'd4, 5'd0, 1'b0, 32'h55};
        v[3] = '{5'd0, 5'd0, 1'b1, 32'h55};
`else
        v[0] = '{5'd4, 5'd4, 1'b1, 32'h55};
        v[1] = '{5'd4, 5'd0, 1'b1, 32'h55};
        v[2] = '{5'd4, 5'd0, 1'b0, 32'h55};
        v[3] = '{5'd0, 5'd0, 1'b1, 32'h55};
`endif
        go_idle();
        for (int i = 0; i < 4; i++) begin
            bus.exm_wr_en  = 1'b1;
            bus.exm_rd     = v[i].exm_rd;
            bus.exm_result = 32'hAA;
            bus.mwb_wr_en  = v[i].mwb_en;
            bus.mwb_rd     = v[i].rs;
            bus.mwb_result = 32'hBB;
            drive(6'h00, 6'h20, v[i].rs, 5'd2, 5'd3, 32'h55, 32'h7, 16'h0);
            @(negedge clk);
            tests_run++;
            if ({bus.alu_a, bus.alu_b} !== {v[i].a, 32'h7}) begin
                tests_failed++; $display("FAIL fwd_case%0d: got a=%h b=%h want a=%h b=7", i, bus.alu_a, bus.alu_b, v[i].a);
            end
        end
        clear_fwd();
        go_idle();
    endtask

    task automatic test_load_use();
        logic exp_lu;
`ifdef ID_EX_FWD_EN
        exp_lu = 1'b1;
`else
        exp_lu = 1'b0;
`endif
        go_idle();
        bus.out_ready = 1'b0;
        drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h33, 32'h1, 16'h0);
        @(negedge clk);
        bus.exm_is_load = 1'b1;
        bus.exm_wr_en   = 1'b1;
        bus.exm_rd      = 5'd6;
        drive(6'h00, 6'h20, 5'd1, 5'd6, 5'd7, 32'h44, 32'h2, 16'h0);
        #1;
        tests_run++;
        if ({bus.load_use, bus.in_ready} !== {exp_lu, 1'b0}) begin
            tests_failed++; $display("FAIL lu_rt_stall: got lu=%b rdy=%b want lu=%b rdy=0", bus.load_use, bus.in_ready, exp_lu);
        end
        bus.flush = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL lu_flush: got out_valid=%b want 0", bus.out_valid); end
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.in_ready !== ~exp_lu) begin tests_failed++; $display("FAIL lu_in_ready: got %b want %b", bus.in_ready, ~exp_lu); end
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== ~exp_lu) begin tests_failed++; $display("FAIL lu_capture: got out_valid=%b want %b", bus.out_valid, ~exp_lu); end
        // lw does not read rt, so a match on rt alone is no hazard
        drive(6'h23, 6'h00, 5'd1, 5'd6, 5'd0, 32'h44, 32'h2, 16'h4);
        #1;
        tests_run++;
        if ({bus.load_use, bus.in_ready} !== 2'b01) begin
            tests_failed++; $display("FAIL lu_lw_rt: got lu=%b rdy=%b want lu=0 rdy=1", bus.load_use, bus.in_ready);
        end
        drive(6'h23, 6'h00, 5'd6, 5'd8, 5'd0, 32'h44, 32'h2, 16'h4);
        #1;
        tests_run++;
        if (bus.load_use !== exp_lu) begin tests_failed++; $display("FAIL lu_lw_rs: got %b want %b", bus.load_use, exp_lu); end
        bus.exm_rd = 5'd0;
        drive(6'h00, 6'h20, 5'd0, 5'd0, 5'd3, 32'h44, 32'h2, 16'h0);
        #1;
        tests_run++;
        if (bus.load_use !== 1'b0) begin tests_failed++; $display("FAIL lu_r0: got %b want 0", bus.load_use); end
        clear_fwd();
        go_idle();
    endtask

    task automatic test_reset_mid();
        go_idle();
        bus.out_ready = 1'b0;
        drive(6'h00, 6'h25, 5'd1, 5'd2, 5'd9, 32'h99, 32'h98, 16'h0);
        @(negedge clk);
        tests_run++;
        if ({bus.out_valid, bus.alu_a} !== {1'b1, 32'h99}) begin tests_failed++; $display("FAIL mid_pre: got v=%b a=%h want 1 99", bus.out_valid, bus.alu_a); end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.out_valid, bus.alu_a, bus.alu_b, bus.alucontrol, bus.dst_idx, bus.reg_wr_en} !== 75'h0) begin
            tests_failed++; $display("FAIL mid_reset: got v=%b a=%h b=%h ctl=%b dst=%0d wr=%b want all 0",
                bus.out_valid, bus.alu_a, bus.alu_b, bus.alucontrol, bus.dst_idx, bus.reg_wr_en);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({bus.out_valid, bus.alu_a} !== {1'b0, 32'h0}) begin tests_failed++; $display("FAIL mid_after: got v=%b a=%h want 0 0", bus.out_valid, bus.alu_a); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_rtype();
        test_alu_funct();
        test_immediate();
        test_backpressure();
        test_forward();
        test_load_use();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
